// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/flag controller for an async FIFO: binary/Gray write
// pointer, read-pointer synchroniser, registered full/almost-full/level/overflow.
module wptr_full_ctrl #(
   parameter int ASIZE       = 4,
   parameter int AFULL_LEVEL = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic             winc,
   input  logic [ASIZE:0]   rptr,
   input  logic             wovf_clr,
   output logic [ASIZE-1:0] waddr,
   output logic             wclken,
   output logic [ASIZE:0]   wptr,
   output logic             wfull,
   output logic             wafull,
   output logic [ASIZE:0]   wlevel,
   output logic             woverflow
);

   localparam logic [ASIZE:0] AFULL_L = (ASIZE+1)'(AFULL_LEVEL);

   logic [ASIZE:0] sync_q [SYNC_STAGES];
   logic [ASIZE:0] wq_rptr;
   logic [ASIZE:0] rbin;

   logic [ASIZE:0] wbin_q,  wbin_d;
   logic [ASIZE:0] wptr_q,  wptr_d;
   logic [ASIZE:0] level_q, level_d;
   logic           wfull_q, wfull_d;
   logic           wafull_q, wafull_d;
   logic           wovf_q,  wovf_d;
   logic           inc;

   assign wq_rptr = sync_q[SYNC_STAGES-1];

   // Bit i of a Gray-to-binary conversion is the XOR of all Gray bits at or above i.
   always_comb begin
      rbin = '0;
      for (int unsigned i = 0; i <= ASIZE; i++) begin
         rbin[i] = ^(wq_rptr >> i);
      end
   end

   always_comb begin
      inc      = winc & ~wfull_q;
      wbin_d   = wbin_q + (ASIZE+1)'(inc);
      wptr_d   = (wbin_d >> 1) ^ wbin_d;
      // Full when next write pointer is exactly one lap ahead of the read pointer.
      wfull_d  = (wptr_d == {~wq_rptr[ASIZE:ASIZE-1], wq_rptr[ASIZE-2:0]});
      level_d  = wbin_d - rbin;
      wafull_d = (level_d >= AFULL_L);
      wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         wbin_q   <= '0;
         wptr_q   <= '0;
         level_q  <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         sync_q[0] <= rptr;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         wbin_q   <= wbin_d;
         wptr_q   <= wptr_d;
         level_q  <= level_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wovf_q   <= wovf_d;
      end
   end

   assign waddr     = wbin_q[ASIZE-1:0];
   assign wclken    = winc & ~wfull_q;
   assign wptr      = wptr_q;
   assign wfull     = wfull_q;
   assign wafull    = wafull_q;
   assign wlevel    = level_q;
   assign woverflow = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl: directed test-plan steps followed by
// randomized traffic, checked against an occupancy-count reference model.
module tb_wptr_full_ctrl;

   localparam int ASIZE = 4;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int SS    = 2;

   logic             wclk = 1'b0;
   logic             wrst, winc, wovf_clr;
   logic [ASIZE:0]   rptr;
   logic [ASIZE-1:0] waddr;
   logic             wclken, wfull, wafull, woverflow;
   logic [ASIZE:0]   wptr, wlevel;

   wptr_full_ctrl #(.ASIZE(ASIZE), .AFULL_LEVEL(AFL), .SYNC_STAGES(SS)) dut (
      .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr), .wovf_clr(wovf_clr),
      .waddr(waddr), .wclken(wclken), .wptr(wptr), .wfull(wfull),
      .wafull(wafull), .wlevel(wlevel), .woverflow(woverflow)
   );

   always #5 wclk = ~wclk;

   int errors = 0;
   int checks = 0;

   // Reference model: total writes accepted, total reads done, and the read
   // count the write side can see (delayed by the synchroniser depth).
   int wr = 0;
   int rd = 0;
   int m_level = 0;
   bit m_full = 0;
   bit m_ovf = 0;
   int hist[$];

   function automatic logic [ASIZE:0] gray(int n);
      logic [ASIZE:0] b;
      b = n[ASIZE:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(bit w, bit clr, bit rst);
      int seen;
      winc = w; wovf_clr = clr; wrst = rst; rptr = gray(rd);
      #1;
      chk("wclken", 32'(wclken), 32'(w & ~m_full));
      @(posedge wclk);
      if (rst) begin
         wr = 0; m_level = 0; m_full = 0; m_ovf = 0;
         hist.delete();
         for (int i = 0; i < SS; i++) hist.push_back(0);
      end else begin
         seen = hist[0];
         void'(hist.pop_front());
         hist.push_back(rd);
         if (w && m_full) m_ovf = 1;
         else if (clr) m_ovf = 0;
         if (w && !m_full) wr++;
         m_level = wr - seen;
         m_full  = (m_level == DEPTH);
      end
      #1;
      chk("waddr",     32'(waddr),     32'(wr % DEPTH));
      chk("wptr",      32'(wptr),      32'(gray(wr)));
      chk("wfull",     32'(wfull),     32'(m_full));
      chk("wafull",    32'(wafull),    32'(m_level >= AFL));
      chk("wlevel",    32'(wlevel),    32'(m_level));
      chk("woverflow", 32'(woverflow), 32'(m_ovf));
   endtask

   initial begin
      bit w, c;
      winc = 0; wovf_clr = 0; wrst = 1; rptr = '0;

      // Reset
      rd = 0;
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      chk("reset_wlevel", 32'(wlevel), 32'd0);

      // Fill
      for (int i = 0; i < 16; i++) begin
         cycle(1, 0, 0);
         if (i == 11) chk("fill_afull_at12", 32'(wafull), 32'd1);
         if (i == 14) chk("fill_not_full15", 32'(wfull), 32'd0);
      end
      chk("fill_wptr",   32'(wptr),   32'b11000);
      chk("fill_wlevel", 32'(wlevel), 32'd16);

      // Overflow, then clear
      for (int i = 0; i < 3; i++) cycle(1, 0, 0);
      chk("ovf_wptr", 32'(wptr), 32'b11000);
      chk("ovf_set",  32'(woverflow), 32'd1);
      cycle(0, 1, 0);
      chk("ovf_clr", 32'(woverflow), 32'd0);

      // Drain visibility: rptr = gray(4)
      rd = 4;
      cycle(0, 0, 0);
      chk("drain_full_N",  32'(wfull), 32'd1);
      cycle(0, 0, 0);
      chk("drain_full_N1", 32'(wfull), 32'd1);
      cycle(0, 0, 0);
      chk("drain_full_N2", 32'(wfull), 32'd0);
      chk("drain_level",   32'(wlevel), 32'd12);
      chk("drain_afull",   32'(wafull), 32'd1);

      // Clear/set collision
      for (int i = 0; i < 4; i++) cycle(1, 0, 0);
      chk("coll_full", 32'(wfull), 32'd1);
      cycle(1, 1, 0);
      chk("coll_ovf", 32'(woverflow), 32'd1);

      // Mid-operation reset
      rd = 0;
      cycle(0, 0, 1);
      for (int i = 0; i < 7; i++) cycle(1, 0, 0);
      cycle(1, 0, 1);
      chk("mrst_waddr", 32'(waddr), 32'd0);
      chk("mrst_wptr",  32'(wptr),  32'd0);
      cycle(1, 0, 0);
      chk("mrst_next_waddr", 32'(waddr), 32'd1);

      // Wrap: reach wbin=28 with reads caught up, then write 16
      rd = 0;
      cycle(0, 0, 1);
      for (int i = 0; i < 28; i++) begin
         if (rd < wr) rd++;
         cycle(1, 0, 0);
      end
      rd = 28;
      for (int i = 0; i < 3; i++) cycle(0, 0, 0);
      chk("wrap_rptr", 32'(rptr), 32'b10010);
      for (int i = 0; i < 16; i++) begin
         cycle(1, 0, 0);
         if (i < 15) chk("wrap_nofull", 32'(wfull), 32'd0);
      end
      chk("wrap_full",  32'(wfull),  32'd1);
      chk("wrap_level", 32'(wlevel), 32'd16);
      chk("wrap_waddr", 32'(waddr),  32'd12);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 9) < 6);
         c = ($urandom_range(0, 15) == 0);
         if (rd < wr && $urandom_range(0, 1) == 1) rd++;
         cycle(w, c, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO. It sits directly upstream of the dual-port FIFO memory and drives its write address, write clock-enable and full inputs. Each cycle it advances a binary/Gray write pointer and synchronises the read-domain Gray pointer into wclk. From those it produces registered full, almost-full, fill-level and sticky-overflow status.

Parameters:
ASIZE, 4, memory address bits; DEPTH = 2**ASIZE; ASIZE >= 2 required
AFULL_LEVEL, 12, wlevel at or above which wafull asserts; legal range 1..DEPTH
SYNC_STAGES, 2, flops in the rptr synchroniser; legal range 2..4

Ports:
wclk  input  1  write-domain clock; sole clock of the block
wrst  input  1  synchronous, active-high reset
winc  input  1  write request from the producer
rptr  input  ASIZE+1  Gray read pointer from the read domain (asynchronous to wclk)
wovf_clr  input  1  clears woverflow
waddr  output  ASIZE  memory write address = wbin[ASIZE-1:0]
wclken  output  1  memory write enable = winc & ~wfull (combinational)
wptr  output  ASIZE+1  registered Gray write pointer, sent to the read domain
wfull  output  1  FIFO full, registered
wafull  output  1  almost full, registered
wlevel  output  ASIZE+1  occupancy as seen by the write domain, 0..DEPTH, registered
woverflow  output  1  sticky: a write was attempted while full

Behaviour:
- Clock and reset: one clock, wclk. wrst is synchronous and active-high, sampled on the posedge of wclk.
- Reset values: wbin=0, wptr=0, all synchroniser flops=0, wfull=0, wafull=0, wlevel=0, woverflow=0. waddr is therefore 0 and wclken equals winc.
- Reset mid-operation: all state returns to reset values on that edge. No write is counted on that edge, even if winc=1.
- Pointer advance: wbinnext = wbin + (winc & ~wfull), modulo 2**(ASIZE+1). wgraynext = (wbinnext>>1) ^ wbinnext. Both are registered every cycle.
- Write latency: a write accepted at edge N uses the waddr present before edge N. waddr increments at edge N.
- Synchroniser: rptr passes through SYNC_STAGES flops to give wq_rptr. No logic is allowed between the synchroniser flops.
- Full: on each edge, wfull <= (wgraynext == {~wq_rptr[ASIZE:ASIZE-1], wq_rptr[ASIZE-2:0]}). The compare uses the next pointer, so wfull asserts on the same edge as the write that fills the FIFO.
- Level: wlevel <= wbinnext - gray2bin(wq_rptr), modulo 2**(ASIZE+1). The result must stay in 0..DEPTH whenever rptr is legal.
- Almost full: wafull <= (levelnext >= AFULL_LEVEL), where levelnext is the value being loaded into wlevel.
- Flag latency after a read: a rptr change stable before edge N shows in wq_rptr after edge N+SYNC_STAGES-1. wfull, wlevel and wafull reflect it after edge N+SYNC_STAGES.
- Pessimism: flags are conservative by design. They may show the FIFO fuller than it is, never emptier.
- Write while full: winc=1 with wfull=1 leaves wbin and wptr unchanged. wclken=0, and woverflow sets on that edge.
- woverflow priority: if the set condition and wovf_clr coincide, set wins. Otherwise wovf_clr=1 clears it on the next edge.
- Simultaneous write and read-pointer advance: the level computation uses both. A pending write and a freed slot on the same edge produce no net change.
- Wrap-around: the MSB of wbin toggles every DEPTH writes. Full and level must be correct across the 2**(ASIZE+1) -> 0 wrap.

Test Plan:
(All scenarios use ASIZE=4, AFULL_LEVEL=12, SYNC_STAGES=2.)
1. Fill: reset, rptr=0, winc=1 for 16 cycles -> waddr 0..15 in order, wptr follows Gray 0,1,3,2,6,... Edge 12 gives wlevel=12 and wafull=1. Edge 16 gives wfull=1, wlevel=16, wptr=5'b11000.
2. Overflow: from full, winc=1 for 3 cycles -> wclken=0, wptr stays 5'b11000, waddr stays 0, woverflow=1. Then wovf_clr=1 for 1 cycle with winc=0 -> woverflow=0.
3. Drain visibility: from full, set rptr=5'b00110 (gray 4) before edge N -> wfull stays 1 through edge N+1, drops to 0 after edge N+2. Also wlevel=12 and wafull=1.
4. Wrap: write 28 and read-advance 28 so wbin=28, rptr=gray(28)=5'b10010. Then write 16 -> wbin wraps to 12, wfull=1, wlevel=16. No spurious full before the 16th write.
5. Clear/set collision: woverflow=0, full, winc=1 and wovf_clr=1 on the same cycle -> woverflow=1.
6. Mid-op reset: at wbin=7 with winc=1, assert wrst for 1 cycle -> next edge waddr=0, wptr=0, wlevel=0, flags 0. The next write goes to address 0.
